// File: rtl/spc_node_ctrl_pkg.sv
// Shared widths, LLR bus type, FSM encoding and chunk-index helpers for the SPC node sequencer.
package spc_node_ctrl_pkg;

   localparam int LLR_INTERNAL_LEN     = 6;
   localparam int PROCESS_UNIT_LLR_NUM = 16;
   localparam int LLR_BUS_W            = LLR_INTERNAL_LEN * PROCESS_UNIT_LLR_NUM;
   localparam int MAX_CHUNKS_DEF       = 8;
   localparam int GIDX_W               = 7;

   typedef logic [LLR_BUS_W-1:0]        llr_bus_t;
   typedef logic [LLR_INTERNAL_LEN-1:0] llr_mag_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_DRAIN = 3'd2,
      ST_FIX   = 3'd3,
      ST_OUT   = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   function automatic int chunk_idx_w(input int max_chunks);
      return (max_chunks > 1) ? $clog2(max_chunks) : 1;
   endfunction

   localparam int CHUNK_W_DEF = chunk_idx_w(MAX_CHUNKS_DEF);

endpackage

// File: rtl/spc_node_ctrl_if.sv
// LLR memory read port plus corrected-bit ready/valid port of the SPC node sequencer.
interface spc_node_ctrl_if #(
   parameter int ADDR_W  = 8,
   parameter int CHUNK_W = 3
) ();
   import spc_node_ctrl_pkg::*;

   logic               llr_rd_en;
   logic [ADDR_W-1:0]  llr_rd_addr;
   llr_bus_t           llr_rd_data;
   logic               bit_vld;
   logic               bit_rdy;
   logic [15:0]        bit_data;
   logic [CHUNK_W-1:0] bit_chunk;

   modport master (
      output llr_rd_en, llr_rd_addr, bit_vld, bit_data, bit_chunk,
      input  llr_rd_data, bit_rdy
   );

   modport slave (
      input  llr_rd_en, llr_rd_addr, bit_vld, bit_data, bit_chunk,
      output llr_rd_data, bit_rdy
   );

endinterface

// File: rtl/spc_chunk_min16.sv
// Combinational 16-lane |LLR|, hard decision, chunk parity and min-|LLR| tree (lower lane wins ties).
module spc_chunk_min16
   import spc_node_ctrl_pkg::*;
(
   input  llr_bus_t    llr,
   input  logic [15:0] lane_en,
   output logic [15:0] hard,
   output logic        par,
   output llr_mag_t    min_mag,
   output logic [3:0]  min_lane
);

   llr_mag_t   mag [16];
   llr_mag_t   m1 [8];
   llr_mag_t   m2 [4];
   llr_mag_t   m3 [2];
   logic [3:0] i1 [8];
   logic [3:0] i2 [4];
   logic [3:0] i3 [2];

   always_comb begin
      llr_mag_t lane;
      hard     = '0;
      min_mag  = '1;
      min_lane = '0;
      for (int k = 0; k < 16; k++) begin
         lane    = llr[LLR_INTERNAL_LEN*k +: LLR_INTERNAL_LEN];
         hard[k] = lane_en[k] & lane[LLR_INTERNAL_LEN-1];
         // Disabled lanes read as the largest magnitude so they never win the min.
         if (!lane_en[k])
            mag[k] = '1;
         else if (lane[LLR_INTERNAL_LEN-1])
            mag[k] = ~lane + llr_mag_t'(1);
         else
            mag[k] = lane;
      end
      par = ^hard;

      // Right operand replaces left only when strictly smaller.
      for (int i = 0; i < 8; i++) begin
         m1[i] = (mag[2*i+1] < mag[2*i]) ? mag[2*i+1] : mag[2*i];
         i1[i] = (mag[2*i+1] < mag[2*i]) ? 4'(2*i+1) : 4'(2*i);
      end
      for (int i = 0; i < 4; i++) begin
         m2[i] = (m1[2*i+1] < m1[2*i]) ? m1[2*i+1] : m1[2*i];
         i2[i] = (m1[2*i+1] < m1[2*i]) ? i1[2*i+1] : i1[2*i];
      end
      for (int i = 0; i < 2; i++) begin
         m3[i] = (m2[2*i+1] < m2[2*i]) ? m2[2*i+1] : m2[2*i];
         i3[i] = (m2[2*i+1] < m2[2*i]) ? i2[2*i+1] : i2[2*i];
      end
      min_mag  = (m3[1] < m3[0]) ? m3[1] : m3[0];
      min_lane = (m3[1] < m3[0]) ? i3[1] : i3[0];
   end

endmodule

// File: rtl/spc_node_ctrl.sv
// SPC node sequencer: reads C chunks, flips min-|LLR| bit on odd parity, emits chunks; done at 2C+3 cycles
// after start with bit_rdy high, stalls in OUT while bit_rdy=0. SPC_CTRL_PIPE_EN adds one compare-stage cycle.
module spc_node_ctrl
   import spc_node_ctrl_pkg::*;
#(
   parameter int MAX_CHUNKS = 8,
   parameter int ADDR_W     = 8,
   parameter int RD_LAT     = 1,
   localparam int CHUNK_W   = chunk_idx_w(MAX_CHUNKS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2:0]        node_len_log,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic              parity_err,
   output logic [GIDX_W-1:0] min_idx,
   spc_node_ctrl_if.master   io
);

   state_t             state, state_nxt;
   logic [2:0]         len_eff;
   logic [CHUNK_W-1:0] last_nxt, last_q, rd_cnt, out_cnt;
   logic               half_q;
   logic [ADDR_W-1:0]  base_q;
   logic               rd_en, bit_vld;

   logic               parity_acc;
   llr_mag_t           min_mag_acc;
   logic [GIDX_W-1:0]  min_idx_acc;
   logic [15:0]        bit_buf [MAX_CHUNKS];

   logic [RD_LAT-1:0]  tag_vld;
   logic [CHUNK_W-1:0] tag_chunk [RD_LAT];
   logic               acc_vld;
   logic [CHUNK_W-1:0] acc_chunk;
   llr_bus_t           acc_dat;

   logic [15:0]        lane_en, cm_hard;
   logic               cm_par;
   llr_mag_t           cm_mag;
   logic [3:0]         cm_lane;
   logic [CHUNK_W-1:0] fix_chunk;
   logic [3:0]         fix_lane;

   always_comb begin
      len_eff = node_len_log;
      if (node_len_log < 3'd3 || 32'(node_len_log) > 4 + CHUNK_W)
         len_eff = 3'd4;
      last_nxt = '0;
      if (len_eff > 3'd4)
         last_nxt = CHUNK_W'((32'd1 << (len_eff - 3'd4)) - 32'd1);
   end

`ifdef SPC_CTRL_PIPE_EN
   logic               stg_vld;
   logic [CHUNK_W-1:0] stg_chunk;
   llr_bus_t           stg_dat;

   always_ff @(posedge clk) begin
      if (rst) begin
         stg_vld   <= 1'b0;
         stg_chunk <= '0;
         stg_dat   <= '0;
      end else begin
         stg_vld   <= tag_vld[RD_LAT-1];
         stg_chunk <= tag_chunk[RD_LAT-1];
         stg_dat   <= io.llr_rd_data;
      end
   end

   assign acc_vld   = stg_vld;
   assign acc_chunk = stg_chunk;
   assign acc_dat   = stg_dat;
`else
   assign acc_vld   = tag_vld[RD_LAT-1];
   assign acc_chunk = tag_chunk[RD_LAT-1];
   assign acc_dat   = io.llr_rd_data;
`endif

   assign lane_en   = half_q ? 16'h00FF : 16'hFFFF;
   assign fix_chunk = min_idx_acc[4 +: CHUNK_W];
   assign fix_lane  = min_idx_acc[3:0];

   spc_chunk_min16 u_min16 (
      .llr      (acc_dat),
      .lane_en  (lane_en),
      .hard     (cm_hard),
      .par      (cm_par),
      .min_mag  (cm_mag),
      .min_lane (cm_lane)
   );

   always_comb begin
      state_nxt = state;
      busy      = (state != ST_IDLE);
      done      = (state == ST_DONE);
      rd_en     = (state == ST_READ);
      bit_vld   = (state == ST_OUT);
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_READ;
         ST_READ:  if (rd_cnt == last_q) state_nxt = ST_DRAIN;
         // Leave once the final chunk is being folded into the accumulators.
         ST_DRAIN: if (acc_vld && acc_chunk == last_q) state_nxt = ST_FIX;
         ST_FIX:   state_nxt = ST_OUT;
         ST_OUT:   if (io.bit_rdy && out_cnt == last_q) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign io.llr_rd_en   = rd_en;
   assign io.llr_rd_addr = rd_en ? base_q + ADDR_W'(rd_cnt) : '0;
   assign io.bit_vld     = bit_vld;
   assign io.bit_data    = bit_vld ? bit_buf[out_cnt] : '0;
   assign io.bit_chunk   = out_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         last_q      <= '0;
         half_q      <= 1'b0;
         base_q      <= '0;
         rd_cnt      <= '0;
         out_cnt     <= '0;
         parity_acc  <= 1'b0;
         min_mag_acc <= '1;
         min_idx_acc <= '0;
         parity_err  <= 1'b0;
         min_idx     <= '0;
         tag_vld     <= '0;
         for (int i = 0; i < RD_LAT; i++) tag_chunk[i] <= '0;
         for (int i = 0; i < MAX_CHUNKS; i++) bit_buf[i] <= '0;
      end else begin
         state        <= state_nxt;
         tag_vld[0]   <= rd_en;
         tag_chunk[0] <= rd_cnt;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_vld[i]   <= tag_vld[i-1];
            tag_chunk[i] <= tag_chunk[i-1];
         end

         case (state)
            ST_IDLE: if (start) begin
               last_q      <= last_nxt;
               half_q      <= (len_eff == 3'd3);
               base_q      <= base_addr;
               rd_cnt      <= '0;
               out_cnt     <= '0;
               parity_acc  <= 1'b0;
               min_mag_acc <= '1;
               min_idx_acc <= '0;
               parity_err  <= 1'b0;
               min_idx     <= '0;
            end
            ST_READ: rd_cnt <= rd_cnt + CHUNK_W'(1);
            ST_FIX: begin
               if (parity_acc)
                  bit_buf[fix_chunk][fix_lane] <= ~bit_buf[fix_chunk][fix_lane];
               parity_err <= parity_acc;
               min_idx    <= min_idx_acc;
            end
            ST_OUT: if (io.bit_rdy)
               out_cnt <= (out_cnt == last_q) ? '0 : out_cnt + CHUNK_W'(1);
            default: ;
         endcase

         // Chunks arrive in ascending order, so strict less-than keeps the lowest global index on ties.
         if (acc_vld) begin
            bit_buf[acc_chunk] <= cm_hard;
            parity_acc         <= parity_acc ^ cm_par;
            if (cm_mag < min_mag_acc) begin
               min_mag_acc <= cm_mag;
               min_idx_acc <= GIDX_W'({acc_chunk, cm_lane});
            end
         end
      end
   end

endmodule

// File: tb/tb_spc_node_ctrl.sv
// Directed bench for spc_node_ctrl: hand-computed chunks, parity/min results, latency, stalls and resets.
module tb_spc_node_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  node_len_log;
   logic [7:0]  base_addr;
   logic        busy, done, parity_err;
   logic [6:0]  min_idx;

   int n_chk = 0;
   int n_err = 0;

   logic [95:0] mem [256];
   logic [15:0] rx_dat [$];
   int          rx_chk [$];
   logic [15:0] exp_dat [8];

`ifdef SPC_CTRL_PIPE_EN
   localparam int PIPE = 1;
`else
   localparam int PIPE = 0;
`endif

   spc_node_ctrl_if #(.ADDR_W(8), .CHUNK_W(3)) bus ();

   spc_node_ctrl #(.MAX_CHUNKS(8), .ADDR_W(8), .RD_LAT(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .node_len_log (node_len_log),
      .base_addr    (base_addr),
      .busy         (busy),
      .done         (done),
      .parity_err   (parity_err),
      .min_idx      (min_idx),
      .io           (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (bus.llr_rd_en) bus.llr_rd_data <= mem[bus.llr_rd_addr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic fill(input int addr, input int n, input int val);
      for (int a = addr; a < addr + n; a++)
         for (int k = 0; k < 16; k++) mem[a][6*k +: 6] = 6'(val);
   endtask

   task automatic set_lane(input int addr, input int lane, input int val);
      mem[addr][6*lane +: 6] = 6'(val);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"},  32'(busy), 0);
      chk({tag, "_done"},  32'(done), 0);
      chk({tag, "_perr"},  32'(parity_err), 0);
      chk({tag, "_minix"}, 32'(min_idx), 0);
      chk({tag, "_rden"},  32'(bus.llr_rd_en), 0);
      chk({tag, "_addr"},  32'(bus.llr_rd_addr), 0);
      chk({tag, "_vld"},   32'(bus.bit_vld), 0);
      chk({tag, "_data"},  32'(bus.bit_data), 0);
      chk({tag, "_chunk"}, 32'(bus.bit_chunk), 0);
   endtask

   // rdy_mode: 0 = ready always high, 1 = ready toggles each cycle.
   task automatic run_node(input logic [2:0] len, input logic [7:0] base, input int rdy_mode,
                           input int dup_cyc, output int done_cyc, output int done_cnt);
      logic        prev_stall;
      logic [15:0] prev_dat;
      logic [2:0]  prev_chunk;
      int          post;
      rx_dat.delete();
      rx_chk.delete();
      done_cyc   = -1;
      done_cnt   = 0;
      post       = 0;
      prev_stall = 1'b0;
      prev_dat   = '0;
      prev_chunk = '0;
      @(posedge clk); #1;
      start        = 1'b1;
      node_len_log = len;
      base_addr    = base;
      bus.bit_rdy  = 1'b1;
      for (int cyc = 1; cyc < 400 && post < 3; cyc++) begin
         @(posedge clk); #1;
         start = (cyc == dup_cyc);
         if (start) begin
            node_len_log = 3'd7;
            base_addr    = 8'd200;
         end
         bus.bit_rdy = (rdy_mode == 1) ? cyc[0] : 1'b1;
         if (prev_stall) begin
            chk("stall_vld",   32'(bus.bit_vld), 1);
            chk("stall_data",  32'(bus.bit_data), 32'(prev_dat));
            chk("stall_chunk", 32'(bus.bit_chunk), 32'(prev_chunk));
         end
         if (bus.bit_vld && bus.bit_rdy) begin
            rx_dat.push_back(bus.bit_data);
            rx_chk.push_back(int'(bus.bit_chunk));
         end
         prev_stall = bus.bit_vld && !bus.bit_rdy;
         prev_dat   = bus.bit_data;
         prev_chunk = bus.bit_chunk;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc >= 0) post++;
      end
      start = 1'b0;
      if (done_cyc < 0) chk("done_timeout", 0, 1);
   endtask

   task automatic chk_rx(input string tag, input int n);
      chk({tag, "_nchunks"}, 32'(rx_dat.size()), 32'(n));
      for (int i = 0; i < n && i < rx_dat.size(); i++) begin
         chk($sformatf("%s_data%0d", tag, i), 32'(rx_dat[i]), 32'(exp_dat[i]));
         chk($sformatf("%s_chunk%0d", tag, i), 32'(rx_chk[i]), 32'(i));
      end
   endtask

   initial begin
      int dc, dn;
      int wait_cyc;
      rst          = 1'b1;
      start        = 1'b0;
      node_len_log = 3'd4;
      base_addr    = '0;
      bus.bit_rdy  = 1'b0;
      for (int a = 0; a < 256; a++) mem[a] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_idle("reset");
      rst = 1'b0;

      // N=16: lane 3 is the only negative and the smallest -> flipped back to 0
      fill(0, 1, 5);
      set_lane(0, 3, -2);
      run_node(3'd4, 8'd0, 0, -1, dc, dn);
      exp_dat[0] = 16'h0000;
      chk_rx("n16", 1);
      chk("n16_minidx", 32'(min_idx), 3);
      chk("n16_perr", 32'(parity_err), 1);
      chk("n16_donecyc", 32'(dc), 32'(5 + PIPE));
      chk("n16_donecnt", 32'(dn), 1);

      // N=64 with an ignored start while busy
      fill(10, 4, 10);
      set_lane(12, 7, -1);
      set_lane(10, 0, -20);
      run_node(3'd6, 8'd10, 0, 3, dc, dn);
      exp_dat[0] = 16'h0001; exp_dat[1] = 16'h0000;
      exp_dat[2] = 16'h0080; exp_dat[3] = 16'h0000;
      chk_rx("n64", 4);
      chk("n64_perr", 32'(parity_err), 0);
      chk("n64_minidx", 32'(min_idx), 39);
      chk("n64_donecyc", 32'(dc), 32'(11 + PIPE));
      chk("n64_donecnt", 32'(dn), 1);

      // N=32, -32 everywhere except one +1: odd parity, bit 31 flipped to 1
      fill(20, 2, -32);
      set_lane(21, 15, 1);
      run_node(3'd5, 8'd20, 0, -1, dc, dn);
      exp_dat[0] = 16'hFFFF; exp_dat[1] = 16'hFFFF;
      chk_rx("n32", 2);
      chk("n32_minidx", 32'(min_idx), 31);
      chk("n32_perr", 32'(parity_err), 1);

      // N=32 tie: |2| at global 5 and 18, lower index is flipped
      fill(30, 2, 9);
      set_lane(30, 5, 2);
      set_lane(31, 2, -2);
      run_node(3'd5, 8'd30, 0, -1, dc, dn);
      exp_dat[0] = 16'h0020; exp_dat[1] = 16'h0004;
      chk_rx("tie", 2);
      chk("tie_minidx", 32'(min_idx), 5);
      chk("tie_perr", 32'(parity_err), 1);

      // N=8: upper lanes are garbage and must be ignored
      fill(40, 1, -1);
      for (int k = 0; k < 8; k++) set_lane(40, k, -3);
      run_node(3'd3, 8'd40, 0, -1, dc, dn);
      exp_dat[0] = 16'h00FF;
      chk_rx("n8", 1);
      chk("n8_minidx", 32'(min_idx), 0);
      chk("n8_perr", 32'(parity_err), 0);
      chk("n8_donecyc", 32'(dc), 32'(5 + PIPE));

      // Illegal length clamps to a single 16-LLR chunk
      run_node(3'd0, 8'd0, 0, -1, dc, dn);
      exp_dat[0] = 16'h0000;
      chk_rx("clamp", 1);
      chk("clamp_minidx", 32'(min_idx), 3);
      chk("clamp_perr", 32'(parity_err), 1);

      // N=128 with toggling ready
      fill(50, 8, 7);
      for (int j = 0; j < 8; j++) begin
         set_lane(50 + j, j, -4);
         exp_dat[j] = 16'(1 << j);
      end
      run_node(3'd7, 8'd50, 1, -1, dc, dn);
      chk_rx("n128", 8);
      chk("n128_minidx", 32'(min_idx), 0);
      chk("n128_perr", 32'(parity_err), 0);
      chk("n128_donecnt", 32'(dn), 1);

      // Reset during READ
      @(posedge clk); #1;
      start = 1'b1; node_len_log = 3'd7; base_addr = 8'd50;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      chk("rdrst_busy", 32'(busy), 1);
      chk("rdrst_rden", 32'(bus.llr_rd_en), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_idle("rdrst");
      rst = 1'b0;

      // Reset during OUT with a latched parity error
      bus.bit_rdy = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; node_len_log = 3'd4; base_addr = 8'd0;
      @(posedge clk); #1;
      start = 1'b0;
      wait_cyc = 0;
      while (!bus.bit_vld && wait_cyc < 20) begin
         @(posedge clk); #1;
         wait_cyc++;
      end
      chk("outrst_vld", 32'(bus.bit_vld), 1);
      chk("outrst_perr", 32'(parity_err), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_idle("outrst");
      rst = 1'b0;

      // Recovery run after the aborts
      run_node(3'd4, 8'd0, 0, -1, dc, dn);
      exp_dat[0] = 16'h0000;
      chk_rx("recov", 1);
      chk("recov_minidx", 32'(min_idx), 3);
      chk("recov_perr", 32'(parity_err), 1);
      chk("recov_donecnt", 32'(dn), 1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
